// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// FETCH_ALIGN_CHECK_EN adds the FAULT state for misaligned redirect targets.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PC_INC     = 4;
  localparam int unsigned ALIGN_MASK = 3;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect priority mux (branch over jump) and target alignment handling.
// FETCH_ALIGN_CHECK_EN: flag misaligned targets instead of masking the low bits.
module fetch_redirect_sel
  import fetch_ctrl_pkg::*;
(
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_addr,
  output logic            redirect_c,
  output logic [XLEN-1:0] target_c
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            misaligned_c
`endif
);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw = '0;
    if (branch_taken) begin
      raw = branch_addr;
    end else if (jump_taken) begin
      raw = jump_addr;
    end
  end

  assign redirect_c = branch_taken | jump_taken;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_c     = raw;
  assign misaligned_c = redirect_c && (raw[1:0] != 2'b00);
`else
  assign target_c = raw & ~XLEN'(ALIGN_MASK);
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential fetch, stall hold and redirect handling.
// FETCH_ALIGN_CHECK_EN: misaligned redirect targets lock into FAULT until reset.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fetch_fault
);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc, pc_d, pc_inc;
  logic [XLEN-1:0] addr_d;
  logic            pend_valid, pend_valid_d;
  logic [XLEN-1:0] pend_addr, pend_addr_d;
  logic            if_valid_d;
  logic [XLEN-1:0] if_instr_d, if_pc_d;
  logic            redirect_c;
  logic [XLEN-1:0] target_c;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            misaligned_c;
`endif

  fetch_redirect_sel u_redirect_sel (
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump_taken   (jump_taken),
    .jump_addr    (jump_addr),
    .redirect_c   (redirect_c),
    .target_c     (target_c)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misaligned_c (misaligned_c)
`endif
  );

  assign pc_inc = pc + XLEN'(PC_INC);

  // Next state; a pending redirect means the outstanding response is stale.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    addr_d       = imem_addr;
    pend_valid_d = pend_valid;
    pend_addr_d  = pend_addr;
    if_valid_d   = if_valid;
    if_instr_d   = if_instr;
    if_pc_d      = if_pc;
    if (!stall || redirect_c) begin
      if_valid_d = 1'b0;
    end
    case (state)
      IDLE: begin
        state_d = REQ;
        if (redirect_c) begin
          pc_d   = target_c;
          addr_d = target_c;
        end else begin
          addr_d = pc;
        end
      end
      REQ: begin
        if (imem_ack) begin
          pend_valid_d = 1'b0;
          if (redirect_c || pend_valid) begin
            pc_d   = redirect_c ? target_c : pend_addr;
            addr_d = redirect_c ? target_c : pend_addr;
          end else begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = imem_addr;
            if (stall) begin
              state_d = HOLD;
            end else begin
              pc_d   = pc_inc;
              addr_d = pc_inc;
            end
          end
        end else if (redirect_c) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = target_c;
        end
      end
      HOLD: begin
        if (redirect_c) begin
          state_d = REQ;
          pc_d    = target_c;
          addr_d  = target_c;
        end else if (!stall) begin
          state_d = REQ;
          pc_d    = pc_inc;
          addr_d  = pc_inc;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: begin
        if_valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (redirect_c && misaligned_c) begin
      state_d      = FAULT;
      if_valid_d   = 1'b0;
      pend_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pend_valid  <= pend_valid_d;
      pend_addr   <= pend_addr_d;
      imem_req    <= (state_d == REQ);
      imem_addr   <= addr_d;
      if_valid    <= if_valid_d;
      if_instr    <= if_instr_d;
      if_pc       <= if_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault <= (state_d == FAULT);
`else
      fetch_fault <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl; expectations follow FETCH_ALIGN_CHECK_EN.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        jump_taken;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] br_addr;
    logic        jt;
    logic [31:0] j_addr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump_taken   (jump_taken),
    .jump_addr    (jump_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .fetch_fault  (fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rst, input logic stl,
                              input logic br, input logic [31:0] br_addr,
                              input logic jt, input logic [31:0] j_addr,
                              input logic ack, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_fault);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.br_addr = br_addr;
    v.jt = jt; v.j_addr = j_addr; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_fault = e_fault;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, then compare the registered outputs.
  task automatic run_vec(input vec_t v, input string name);
    reset        = v.rst;
    stall        = v.stl;
    branch_taken = v.br;
    branch_addr  = v.br_addr;
    jump_taken   = v.jt;
    jump_addr    = v.j_addr;
    imem_ack     = v.ack;
    imem_rdata   = v.rdata;
    @(posedge clk);
    #1;
    nvec++;
    if (imem_req !== v.e_req || imem_addr !== v.e_addr || if_valid !== v.e_valid ||
        if_instr !== v.e_instr || if_pc !== v.e_pc || fetch_fault !== v.e_fault) begin
      nmis++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc=%h fault=%0b, want req=%0b addr=%h valid=%0b instr=%h pc=%h fault=%0b",
               name, imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault,
               v.e_req, v.e_addr, v.e_valid, v.e_instr, v.e_pc, v.e_fault);
    end
  endtask

  vec_t vecs[20];
  logic f;

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    jump_taken = 1'b0; jump_addr = '0; imem_ack = 1'b0; imem_rdata = '0;

    //              rst stl br br_addr        jt j_addr         ack rdata          req addr           vld instr          pc             flt
    vecs[0]  = mk(1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,         0);
    vecs[1]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0,         0);
    vecs[2]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0,         0);
    vecs[3]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hA0,         1, 32'h4,          1, 32'hA0,         32'h0,         0);
    vecs[4]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hA4,         1, 32'h8,          1, 32'hA4,         32'h4,         0);
    vecs[5]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'hA8,         0, 32'h8,          1, 32'hA8,         32'h8,         0);
    vecs[6]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h8,          1, 32'hA8,         32'h8,         0);
    vecs[7]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 32'h8,          1, 32'hA8,         32'h8,         0);
    vecs[8]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'hC,          0, 32'hA8,         32'h8,         0);
    vecs[9]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          1, 32'hC,          0, 32'hA8,         32'h8,         0);
    vecs[10] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hAC,         1, 32'h10,         1, 32'hAC,         32'hC,         0);
    vecs[11] = mk(0, 0, 1, 32'h100,        1, 32'h200,        0, 32'h0,          1, 32'h10,         0, 32'hAC,         32'hC,         0);
    vecs[12] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hDEAD,       1, 32'h100,        0, 32'hAC,         32'hC,         0);
    vecs[13] = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h1000_0000,  0, 32'h100,        1, 32'h1000_0000,  32'h100,       0);
    vecs[14] = mk(0, 1, 0, 32'h0,          1, 32'h40,         0, 32'h0,          1, 32'h40,         0, 32'h1000_0000,  32'h100,       0);
    vecs[15] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h40,         1, 32'h44,         1, 32'h40,         32'h40,        0);
    vecs[16] = mk(0, 0, 1, 32'h300,        0, 32'h0,          1, 32'hBAD,        1, 32'h300,        0, 32'h40,         32'h40,        0);
    vecs[17] = mk(1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h77,         0, 32'h0,          0, 32'h0,          32'h0,         0);
    vecs[18] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h55,         1, 32'h0,          0, 32'h0,          32'h0,         0);
    vecs[19] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h66,         1, 32'h4,          1, 32'h66,         32'h0,         0);

    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // pc wrap: redirect from IDLE to the last word, then sequential step to 0
    run_vec(mk(1, 0, 0, 32'h0, 0, 32'h0,         0, 32'h0,  0, 32'h0,         0, 32'h0,  32'h0,         0), "wrap_reset");
    run_vec(mk(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0,  1, 32'hFFFF_FFFC, 0, 32'h0,  32'h0,         0), "wrap_jump");
    run_vec(mk(0, 0, 0, 32'h0, 0, 32'h0,         1, 32'h12, 1, 32'h0,         1, 32'h12, 32'hFFFF_FFFC, 0), "wrap_next");

    // misaligned branch target
`ifdef FETCH_ALIGN_CHECK_EN
    f = 1'b1;
    run_vec(mk(0, 0, 1, 32'h102, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h12, 32'hFFFF_FFFC, f), "align_fault");
    run_vec(mk(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'h5, 0, 32'h0, 0, 32'h12, 32'hFFFF_FFFC, f), "align_hold_ack");
    run_vec(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h12, 32'hFFFF_FFFC, f), "align_hold");
`else
    f = 1'b0;
    run_vec(mk(0, 0, 1, 32'h102, 0, 32'h0, 0, 32'h0, 1, 32'h0,   0, 32'h12, 32'hFFFF_FFFC, f), "align_pend");
    run_vec(mk(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'h5, 1, 32'h100, 0, 32'h12, 32'hFFFF_FFFC, f), "align_masked");
    run_vec(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 32'h100, 0, 32'h12, 32'hFFFF_FFFC, f), "align_wait");
`endif
    run_vec(mk(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0), "final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, fetch address issued after reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high; sampled on posedge clk.
REQ-004 stall  input  1  decode not ready; holds the presented instruction.
REQ-005 branch_taken  input  1  branch redirect request, valid this cycle.
REQ-006 branch_addr  input  32  branch target.
REQ-007 jump_taken  input  1  jump/jump-register redirect request, valid this cycle.
REQ-008 jump_addr  input  32  jump target.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  request address.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  input  32  fetched word.
REQ-013 if_valid  output  1  if_instr/if_pc valid to decode.
REQ-014 if_instr  output  32  fetched instruction.
REQ-015 if_pc  output  32  address of if_instr.
REQ-016 fetch_fault  output  1  misaligned target detected (macro-dependent).

Function
REQ-017 States SHALL be IDLE, REQ, HOLD, plus FAULT when FETCH_ALIGN_CHECK_EN is defined.
REQ-018 IDLE: imem_req=0; next cycle SHALL go to REQ with imem_addr=pc.
REQ-019 REQ: imem_req=1; imem_addr SHALL stay constant until the cycle imem_ack=1.
REQ-020 On imem_ack in cycle N, with no discard pending: if_instr<=imem_rdata, if_pc<=imem_addr, if_valid=1 in cycle N+1 (registered, latency 1).
REQ-021 After ack, with stall=0 in that cycle: pc<=pc+4, and the next request SHALL issue in cycle N+1 (back-to-back, no IDLE).
REQ-022 After ack with stall=1: go to HOLD; if_valid, if_instr, if_pc held; imem_req=0; leave HOLD the first cycle stall=0, pc<=pc+4, issue in REQ next cycle.
REQ-023 if_valid SHALL drop the cycle after decode consumes (stall=0) unless a new ack arrives in that same cycle.
REQ-024 Redirect priority: branch_taken over jump_taken over sequential; both asserted -> branch_addr wins.
REQ-025 Redirect in IDLE/HOLD: pc<=target; if_valid cleared next cycle; REQ next cycle with the target.
REQ-026 Redirect in REQ before/with ack: target stored in a one-entry pending register (newer redirect overwrites older; same-cycle priority per REQ-024); the outstanding response SHALL be discarded (no if_valid); next request issues to pending target the cycle after ack.
REQ-027 Redirect overrides stall; stall never blocks a redirect.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).

Reset
REQ-029 reset=1 SHALL set state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_fault=0, pending cleared; takes priority over all inputs.
REQ-030 reset mid-REQ SHALL abandon the transaction; a later imem_ack SHALL be ignored until the new request issues.

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN: when defined, a redirect target with addr[1:0]!=0 SHALL enter FAULT next cycle, assert fetch_fault=1, hold imem_req=0 and if_valid=0 until reset.
REQ-032 When undefined: FAULT absent, fetch_fault tied 0, targets used with addr[1:0] forced to 2'b00.

Structure
REQ-033 Shared package SHALL hold the state enum, width constant XLEN=32, and PC increment constant 4.
REQ-034 One sub-module fetch_redirect_sel SHALL implement the redirect priority mux and alignment check (combinational); all state stays in fetch_ctrl.

Verification
REQ-035 Reset release, ack after 1 wait cycle -> imem_addr 0x0, if_valid with if_pc=0x0 one cycle after ack, next imem_addr 0x4.
REQ-036 stall=1 over 3 cycles after ack of 0x8 -> if_instr/if_pc held, imem_req=0; stall drop -> request to 0xC.
REQ-037 branch_taken (0x100) and jump_taken (0x200) same cycle in REQ -> response discarded, next request 0x100.
REQ-038 Jump to 0x40 during stalled HOLD -> if_valid=0 next cycle, request 0x40.
REQ-039 pc at 0xFFFF_FFFC, ack -> next request 0x0.
REQ-040 Macro defined, branch to 0x102 -> fetch_fault=1, no imem_req until reset; undefined -> request 0x100.
